// File: rtl/rsa_ctrl_fsm.sv
// Run controller for rsa_unit: merges start/stop sources, sequences
// enable and reset-release, adds watchdog, re-run mode and status.
module rsa_ctrl_fsm #(
  parameter int NUM_SRC  = 2,
  parameter int CNT_W    = 16,
  parameter bit STOP_AND = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_SRC-1:0] start,
  input  logic [NUM_SRC-1:0] stop,
  input  logic               cont_mode,
  input  logic [CNT_W-1:0]   timeout_cycles,
  input  logic               clr_status,
  input  logic               eoc_rsa_unit,
  output logic               en_rsa,
  output logic               rst_rsa,
  output logic               eoc,
  output logic               busy,
  output logic               done_flag,
  output logic               timeout_flag,
  output logic [CNT_W-1:0]   cycles_out
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_EN    = 3'd2,
    S_RREL  = 3'd3,
    S_WAIT  = 3'd4,
    S_EOC   = 3'd5,
    S_TMO   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;

  logic             start_c;
  logic             stop_c;
  logic             accept;
  logic             set_done;
  logic             set_tmo;
  logic [CNT_W-1:0] tmo_m1;

  assign start_c = |start;
  assign stop_c  = STOP_AND ? &stop : |stop;
  assign tmo_m1  = timeout_cycles - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    done_d   = done_q;
    tmo_d    = tmo_q;
    accept   = 1'b0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        if (start_c && !stop_c) begin
          state_d = S_EN;
          accept  = 1'b1;
        end
      end
      S_EN: state_d = S_RREL;
      S_RREL: begin
        cnt_d   = '0;
        state_d = stop_c ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (stop_c) begin
          state_d = S_IDLE;
        end else if (eoc_rsa_unit) begin
          state_d  = S_EOC;
          cyc_d    = cnt_q;
          set_done = 1'b1;
        end else if (timeout_cycles != '0 &&
                     cnt_q == tmo_m1) begin
          state_d = S_TMO;
          cyc_d   = timeout_cycles;
          set_tmo = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EOC: begin
        state_d = (cont_mode && !stop_c) ? S_EN : S_IDLE;
      end
      S_TMO:   state_d = S_IDLE;
      default: state_d = S_RESET;
    endcase
    // a set in the same cycle as a clear must survive
    if (clr_status || accept) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end
    if (set_done) done_d = 1'b1;
    if (set_tmo)  tmo_d  = 1'b1;
  end

  always_comb begin
    en_rsa  = 1'b0;
    rst_rsa = 1'b0;
    eoc     = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_EN: begin
        en_rsa = 1'b1;
        busy   = 1'b1;
      end
      S_RREL, S_WAIT: begin
        en_rsa  = 1'b1;
        rst_rsa = 1'b1;
        busy    = 1'b1;
      end
      S_EOC: begin
        en_rsa  = 1'b1;
        rst_rsa = 1'b1;
        eoc     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  assign done_flag    = done_q;
  assign timeout_flag = tmo_q;
  assign cycles_out   = cyc_q;

endmodule

// File: tb/tb_rsa_ctrl_fsm.sv
// Bench for rsa_ctrl_fsm: directed scenarios plus random traffic,
// checked every cycle against a run-age reference model.
module tb_rsa_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [1:0]  start = '0;
  logic [1:0]  stop = '0;
  logic        cont_mode = 1'b0;
  logic [15:0] timeout_cycles = '0;
  logic        clr_status = 1'b0;
  logic        eoc_rsa_unit = 1'b0;
  logic        en_rsa, rst_rsa, eoc, busy;
  logic        done_flag, timeout_flag;
  logic [15:0] cycles_out;

  int n_chk = 0;
  int n_err = 0;

  // model: in_reset, run age (0 idle, 1 EN, 2 release,
  // 3+k waiting with count k), post (1 eoc, 2 timeout)
  bit m_inrst;
  int m_age;
  int m_post;
  int m_cyc;
  bit m_done;
  bit m_tmo;

  rsa_ctrl_fsm #(
    .NUM_SRC(2), .CNT_W(16), .STOP_AND(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .start(start), .stop(stop),
    .cont_mode(cont_mode),
    .timeout_cycles(timeout_cycles),
    .clr_status(clr_status),
    .eoc_rsa_unit(eoc_rsa_unit),
    .en_rsa(en_rsa), .rst_rsa(rst_rsa),
    .eoc(eoc), .busy(busy),
    .done_flag(done_flag),
    .timeout_flag(timeout_flag),
    .cycles_out(cycles_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_inrst = 1;
    m_age   = 0;
    m_post  = 0;
    m_cyc   = 0;
    m_done  = 0;
    m_tmo   = 0;
  endfunction

  function automatic void mdl_step();
    bit st, sp, acc, sd, stt;
    int n;
    st  = |start;
    sp  = &stop;
    acc = 0;
    sd  = 0;
    stt = 0;
    if (m_inrst) begin
      m_inrst = 0;
    end else if (m_post == 1) begin
      m_post = 0;
      if (cont_mode && !sp) m_age = 1;
    end else if (m_post == 2) begin
      m_post = 0;
    end else if (m_age == 0) begin
      if (st && !sp) begin
        m_age = 1;
        acc   = 1;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (m_age == 2) begin
      m_age = sp ? 0 : 3;
    end else begin
      n = m_age - 3;
      if (n > 65535) n = 65535;
      if (sp) begin
        m_age = 0;
      end else if (eoc_rsa_unit) begin
        m_cyc  = n;
        m_age  = 0;
        m_post = 1;
        sd     = 1;
      end else if (timeout_cycles != 0 &&
                   n == int'(timeout_cycles) - 1) begin
        m_cyc  = int'(timeout_cycles);
        m_age  = 0;
        m_post = 2;
        stt    = 1;
      end else begin
        m_age++;
      end
    end
    m_done = (m_done && !(clr_status || acc)) || sd;
    m_tmo  = (m_tmo && !(clr_status || acc)) || stt;
  endfunction

  task automatic chk_all(input string t);
    chk({t, ".en"},   en_rsa,
        m_age >= 1 || m_post == 1);
    chk({t, ".rr"},   rst_rsa,
        m_age >= 2 || m_post == 1);
    chk({t, ".eoc"},  eoc, m_post == 1);
    chk({t, ".busy"}, busy, m_age >= 1);
    chk({t, ".done"}, done_flag, m_done);
    chk({t, ".tmo"},  timeout_flag, m_tmo);
    chk({t, ".cyc"},  cycles_out, m_cyc);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst && ena) mdl_step();
    #1;
    chk_all("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mdl_reset();
    chk_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic launch();
    start = 2'b01;
    cycle();
    start = 2'b00;
  endtask

  task automatic wait_cnt(input int n);
    int k = 0;
    while (m_age != n + 3 && k < 3000) begin
      cycle();
      k++;
    end
    chk("wait_to", m_age, n + 3);
  endtask

  int pulses;

  initial begin
    mdl_reset();
    #2;
    chk_all("por");
    do_reset();
    cycle();

    // basic run, eoc on the 11th wait cycle
    launch();
    chk("lat_en", en_rsa, 1);
    chk("lat_rr0", rst_rsa, 0);
    cycle();
    chk("lat_rr1", rst_rsa, 1);
    wait_cnt(10);
    eoc_rsa_unit = 1'b1;
    cycle();
    eoc_rsa_unit = 1'b0;
    chk("b_eoc", eoc, 1);
    chk("b_cyc", cycles_out, 10);
    chk("b_done", done_flag, 1);
    cycle();
    chk("b_eoc1", eoc, 0);
    chk("b_busy", busy, 0);

    // partial stop ignored, full stop aborts
    launch();
    wait_cnt(2);
    stop = 2'b01;
    repeat (3) cycle();
    chk("s_part", busy, 1);
    stop = 2'b11;
    cycle();
    stop = 2'b00;
    chk("s_busy", busy, 0);
    chk("s_en", en_rsa, 0);
    chk("s_cyc", cycles_out, 10);

    // watchdog
    timeout_cycles = 16'd5;
    launch();
    wait_cnt(0);
    repeat (5) cycle();
    chk("t_flag", timeout_flag, 1);
    chk("t_cyc", cycles_out, 5);
    chk("t_en", en_rsa, 0);
    cycle();
    chk("t_idle", busy, 0);
    timeout_cycles = 16'd0;
    launch();
    repeat (1000) cycle();
    chk("t_inf", busy, 1);
    stop = 2'b11;
    cycle();
    stop = 2'b00;

    // continuous mode
    clr_status = 1'b1;
    cycle();
    clr_status = 1'b0;
    cont_mode = 1'b1;
    pulses = 0;
    launch();
    for (int r = 0; r < 3; r++) begin
      wait_cnt(r + 1);
      eoc_rsa_unit = 1'b1;
      cycle();
      eoc_rsa_unit = 1'b0;
      if (eoc) pulses++;
      cycle();
      chk("c_relaunch", en_rsa && !rst_rsa, 1);
    end
    chk("c_pulses", pulses, 3);
    cont_mode = 1'b0;
    wait_cnt(4);
    eoc_rsa_unit = 1'b1;
    cycle();
    eoc_rsa_unit = 1'b0;
    cycle();
    chk("c_idle", busy, 0);
    chk("c_done", done_flag, 1);
    clr_status = 1'b1;
    cycle();
    clr_status = 1'b0;
    chk("c_clr", done_flag, 0);

    // start with stop in idle
    start = 2'b11;
    stop = 2'b11;
    cycle();
    start = 2'b00;
    stop = 2'b00;
    chk("ss_idle", busy, 0);

    // ena freeze: 3 active waits, 4 frozen, 3 more
    launch();
    wait_cnt(3);
    ena = 1'b0;
    repeat (4) cycle();
    chk("f_busy", busy, 1);
    ena = 1'b1;
    wait_cnt(6);
    eoc_rsa_unit = 1'b1;
    cycle();
    eoc_rsa_unit = 1'b0;
    chk("f_cyc", cycles_out, 6);
    cycle();

    // async reset mid-run
    launch();
    wait_cnt(2);
    #2;
    do_reset();
    chk("r_en", en_rsa, 0);
    cycle();
    chk("r_idle", busy, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom % 6 == 0) ? 2'($urandom) : 2'b00;
      stop = ($urandom % 5 == 0) ? 2'($urandom) : 2'b00;
      eoc_rsa_unit = ($urandom % 10 == 0);
      ena = ($urandom % 8 != 0);
      clr_status = ($urandom % 30 == 0);
      if ($urandom % 50 == 0) cont_mode = $urandom;
      if ($urandom % 40 == 0)
        timeout_cycles = ($urandom % 3 == 0) ? 16'd0 :
                         16'($urandom_range(1, 15));
      if ($urandom % 600 == 0) begin
        #2;
        do_reset();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
